iterative_div: RTL

Sequential unsigned restoring divider primitive, one quotient bit per cycle, with a go/done handshake. It sits directly downstream of the combinational arithmetic primitives (Add, Sub, MultComb). It consumes their `left`/`right` results where a full combinational divider would be too large or too slow. Results land in dedicated output registers that hold stable until the next completion.

---
 rtl/iterative_div_pkg.sv | 26 ++
 rtl/iterative_div_step.sv | 48 ++++
 rtl/iterative_div.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/iterative_div_pkg.sv
// ---------------------------------------------------------------------------
// iterative_div_pkg
//
// Purpose: shared definitions for the iterative restoring divider.
//   - div_state_t : control states of the divider sequencer
//   - cnt_width() : width of the iteration counter for a given operand width
//
// No ports (package).
// ---------------------------------------------------------------------------
package iterative_div_pkg;

    // The reset state must encode as all-zeros so that the async reset
    // value of the state register is IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter has to be able to represent values 0..width, so it needs
    // enough bits to hold width itself, not just width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : iterative_div_pkg

// File: rtl/iterative_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//
// Purpose: one purely combinational iteration of an unsigned restoring
// divider. Shifts the next dividend bit into the partial remainder and
// subtracts the divisor when that does not go negative.
//
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before this iteration
//   dvd_msb              dividend bit being brought down this iteration
//   divisor  [WIDTH-1:0] divisor
//   rem_out  [WIDTH:0]   partial remainder after this iteration
//   q_bit                quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    // The partial remainder entering a step is always below the divisor,
    // so its top bit is always zero and is dropped by the shift. It stays
    // in the port so the register width matches the datapath description.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[WIDTH];

    // Bring down one dividend bit, then trial-subtract. The comparison is
    // done at WIDTH+1 bits because the shifted value can reach
    // 2*divisor-1, which does not fit in WIDTH bits.
    always_comb begin
        shifted     = {rem_in[WIDTH-1:0], dvd_msb};
        divisor_ext = {1'b0, divisor};
        rem_out     = shifted;
        q_bit       = 1'b0;
        if (shifted >= divisor_ext) begin
            rem_out = shifted - divisor_ext;
            q_bit   = 1'b1;
        end
    end

endmodule : div_step

// File: rtl/iterative_div.sv
// ---------------------------------------------------------------------------
// iterative_div
//
// Purpose: sequential unsigned restoring divider producing one quotient bit
// per clock, with a go/done handshake and held result registers.
//
// Ports:
//   clk                       rising-edge clock
//   reset_n                   asynchronous active-low reset
//   go                        start request, accepted when ready=1
//   left      [WIDTH-1:0]     dividend, sampled on the accepting edge
//   right     [WIDTH-1:0]     divisor, sampled on the accepting edge
//   ready                     block can accept go this cycle
//   done                      one-cycle completion pulse
//   quotient  [WIDTH-1:0]     registered quotient of the last operation
//   remainder [WIDTH-1:0]     registered remainder of the last operation
//   div_by_zero               registered divide-by-zero flag
//
// Build option:
//   ITERATIVE_DIV_ZERO_DETECT_EN  when defined, a zero divisor completes one
//                                 cycle after accept and raises div_by_zero.
//                                 When undefined, a zero divisor runs the full
//                                 iteration and div_by_zero is constant 0.
// ---------------------------------------------------------------------------
module iterative_div
    import iterative_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_q,   state_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q,     rem_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] quot_q,    quot_d;
    logic [WIDTH-1:0] remn_q,    remn_d;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
    logic             dbz_q,     dbz_d;
`endif

    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    // Single shared iteration; the dividend register doubles as the quotient
    // shift register, so its MSB is the next bit to bring down.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Next-state and datapath logic. IDLE and DONE behave identically with
    // respect to go, which is what allows back-to-back operation from the
    // DONE cycle. The result registers are only written on the transition
    // into DONE so they hold through any following IDLE or BUSY period.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        remn_d    = remn_q;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
        dbz_d     = dbz_q;
`endif

        case (state_q)
            BUSY: begin
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    quot_d  = {dvd_q[WIDTH-2:0], step_bit};
                    remn_d  = step_rem[WIDTH-1:0];
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
`endif
                end
            end

            default: begin
                if (go) begin
                    state_d   = BUSY;
                    dvd_d     = left;
                    divisor_d = right;
                    rem_d     = '0;
                    cnt_d     = '0;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
                    // Zero divisor short-cuts straight to the result the
                    // full iteration would have produced anyway.
                    if (right == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remn_d  = left;
                        dbz_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    // and clears the visible results as well.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            remn_q    <= '0;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            remn_q    <= remn_d;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
            dbz_q     <= dbz_d;
`endif
        end
    end

    // Handshake outputs decode from the registered state only.
    assign ready     = (state_q != BUSY);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = remn_q;
`ifdef ITERATIVE_DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule : iterative_div
